// File: rtl/store_buf_pkg.sv
// Shared types and constants for the store buffer: op encodings,
// the queued entry layout and the byte-enable patterns.
package store_buf_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    typedef struct packed {
        logic [31:2] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the datapath/memory side (master) and the store
// buffer (slave): store request, flush/status, memory write port and
// the load-forwarding lookup.
interface store_buffer_if #(
    parameter int CW = 3
);
    logic          st_valid;
    logic [1:0]    st_op;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_err;
    logic          flush;
    logic          drained;
    logic [CW-1:0] count;
    logic          mem_wvalid;
    logic [31:2]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_wready;
    logic [31:2]   ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic [3:0]    ld_be;

    modport master (
        output st_valid, st_op, st_addr, st_data, flush, mem_wready, ld_addr,
        input  st_ready, st_err, drained, count, mem_wvalid, mem_addr,
               mem_wdata, mem_be, ld_hit, ld_data, ld_be
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, flush, mem_wready, ld_addr,
        output st_ready, st_err, drained, count, mem_wvalid, mem_addr,
               mem_wdata, mem_be, ld_hit, ld_data, ld_be
    );
endinterface

// File: rtl/store_lane_align.sv
// Combinational store alignment: places sw/sh/sb data on the proper
// byte lanes, builds byte enables and flags misaligned addresses.
// The reserved op is not judged here; the caller rejects it.
module store_lane_align
    import store_buf_pkg::*;
(
    input  st_op_e      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    // Replicate the narrow datum across lanes and pick enables by offset.
    always_comb begin
        wdata      = data;
        be         = BE_NONE;
        misaligned = 1'b0;
        case (op)
            ST_SW: begin
                be         = BE_WORD;
                misaligned = (addr_lo != 2'b00);
            end
            ST_SH: begin
                wdata      = {2{data[15:0]}};
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr_lo[0];
            end
            ST_SB: begin
                wdata = {4{data[7:0]}};
                be    = BE_BYTE0 << addr_lo;
            end
            default: begin
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns stores, queues up to DEPTH entries
// and drains them in order to data memory over valid/ready.
// Optional load forwarding is built when STORE_BUF_FWD_EN is defined;
// otherwise ld_hit/ld_data/ld_be are tied low and no comparators exist.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t     entries_reg [DEPTH];
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          err_reg;

    logic [31:0]   al_data;
    logic [3:0]    al_be;
    logic          al_misaligned;
    logic          full;
    logic          ready;
    logic          bad_req;
    logic          enq;
    logic          rej;
    logic          deq;
    sb_entry_t     head_entry;

    store_lane_align u_align (
        .op         (st_op_e'(bus.st_op)),
        .addr_lo    (bus.st_addr[1:0]),
        .data       (bus.st_data),
        .wdata      (al_data),
        .be         (al_be),
        .misaligned (al_misaligned)
    );

    // Full blocks acceptance even if the head leaves this cycle.
    assign full    = (count_reg == CW'(DEPTH));
    assign ready   = !full && !bus.flush;
    assign bad_req = al_misaligned || (st_op_e'(bus.st_op) == ST_RSV);
    assign enq     = bus.st_valid && ready && !bad_req;
    assign rej     = bus.st_valid && ready && bad_req;
    assign deq     = (count_reg != '0) && bus.mem_wready;

    // Occupancy: simultaneous enqueue and dequeue cancel out.
    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, count and the one-cycle reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (enq) tail_reg <= tail_reg + 1'b1;
            if (deq) head_reg <= head_reg + 1'b1;
            count_reg <= count_next;
            err_reg   <= rej;
        end
    end

    // Entry storage; contents are meaningless outside the head..tail window.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_reg[tail_reg] <= '{word_addr: bus.st_addr[31:2],
                                       data:      al_data,
                                       be:        al_be};
        end
    end

    assign head_entry     = entries_reg[head_reg];
    assign bus.st_ready   = ready;
    assign bus.st_err     = err_reg;
    assign bus.drained    = (count_reg == '0);
    assign bus.count      = count_reg;
    assign bus.mem_wvalid = (count_reg != '0);
    assign bus.mem_addr   = head_entry.word_addr;
    assign bus.mem_wdata  = head_entry.data;
    assign bus.mem_be     = head_entry.be;

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH-1:0] slot_match;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic [3:0]       fwd_be;

    // A slot is live when its age behind the head is below count;
    // the head still matches while it is being dequeued.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PW-1:0] age;
            assign age = PW'(gi) - head_reg;
            assign slot_match[gi] = ({1'b0, age} < count_reg) &&
                                    (entries_reg[gi].word_addr == bus.ld_addr);
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_be   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_match[head_reg + PW'(i)]) begin
                fwd_hit  = 1'b1;
                fwd_data = entries_reg[head_reg + PW'(i)].data;
                fwd_be   = entries_reg[head_reg + PW'(i)].be;
            end
        end
    end

    assign bus.ld_hit  = fwd_hit;
    assign bus.ld_data = fwd_data;
    assign bus.ld_be   = fwd_be;
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^bus.ld_addr;
    assign bus.ld_hit  = 1'b0;
    assign bus.ld_data = '0;
    assign bus.ld_be   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scenario tasks drive stores,
// expected memory writes go into a queue and are compared as the buffer
// hands them to memory. Forwarding expectations follow STORE_BUF_FWD_EN.
`timescale 1ns/1ps
module tb_store_buffer;
    import store_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:2] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t got;

    store_buffer_if #(.CW(CW)) sb_if ();

    store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        sb_if.st_valid = 1'b1;
        sb_if.st_op    = op;
        sb_if.st_addr  = addr;
        sb_if.st_data  = data;
        $display("[TB] store op=%b addr=%h data=%h ready=%b", op, addr, data, sb_if.st_ready);
        step();
        sb_if.st_valid = 1'b0;
    endtask

    task automatic push(input logic [31:2] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.be   = b;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sb_if.st_valid = 1'b0; sb_if.st_op = 2'b00; sb_if.st_addr = '0; sb_if.st_data = '0;
        sb_if.flush = 1'b0; sb_if.mem_wready = 1'b0; sb_if.ld_addr = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        n_tests++;
        if ({sb_if.st_ready, sb_if.st_err, sb_if.drained, sb_if.count, sb_if.mem_wvalid, sb_if.ld_hit} !== {1'b1, 1'b0, 1'b1, CW'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_status: got rdy/err/drn/cnt/wv/hit=%b %b %b %0d %b %b, expected 1 0 1 0 0 0",
                     sb_if.st_ready, sb_if.st_err, sb_if.drained, sb_if.count, sb_if.mem_wvalid, sb_if.ld_hit);
        end
        n_tests++;
        if ({sb_if.ld_data, sb_if.ld_be} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_ld: got ld_data=%h ld_be=%b, expected 0 0", sb_if.ld_data, sb_if.ld_be);
        end
    endtask

    task automatic test_sw_basic();
        sb_if.mem_wready = 1'b1;
        push(30'h4, 32'hDEADBEEF, 4'b1111);
        send(ST_SW, 32'h0000_0010, 32'hDEADBEEF);
        n_tests++;
        if (sb_if.mem_wvalid !== 1'b1 || sb_if.count !== CW'(1)) begin
            n_fail++;
            $display("FAIL sw_latency: got mem_wvalid=%b count=%0d, expected 1 1", sb_if.mem_wvalid, sb_if.count);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (sb_if.mem_wvalid && sb_if.mem_wready) begin
                got = exp_q.pop_front();
                n_tests++;
                $display("[TB] drain addr=%h data=%h be=%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
                if ({sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {got.addr, got.data, got.be}) begin
                    n_fail++;
                    $display("FAIL sw_drain: got %h/%h/%b, expected %h/%h/%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be, got.addr, got.data, got.be);
                end
            end
            step();
        end
        n_tests++;
        if (exp_q.size() != 0 || sb_if.count !== CW'(0)) begin
            n_fail++;
            $display("FAIL sw_empty: got %0d pending, count=%0d, expected 0 0", exp_q.size(), sb_if.count);
            exp_q.delete();
        end
    endtask

    task automatic test_sb_sh();
        sb_if.mem_wready = 1'b0;
        send(ST_SB, 32'h0000_0013, 32'h0000_00A5);
        send(ST_SH, 32'h0000_0022, 32'h0000_1234);
        push(30'h4, 32'hA5A5A5A5, 4'b1000);
        push(30'h8, 32'h12341234, 4'b1100);
        n_tests++;
        if (sb_if.count !== CW'(2)) begin
            n_fail++;
            $display("FAIL sbsh_count: got %0d, expected 2", sb_if.count);
        end
        sb_if.mem_wready = 1'b1;
        #1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (sb_if.mem_wvalid && sb_if.mem_wready) begin
                got = exp_q.pop_front();
                n_tests++;
                $display("[TB] drain addr=%h data=%h be=%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
                if ({sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {got.addr, got.data, got.be}) begin
                    n_fail++;
                    $display("FAIL sbsh_drain: got %h/%h/%b, expected %h/%h/%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be, got.addr, got.data, got.be);
                end
            end
            step();
        end
        n_tests++;
        if (exp_q.size() != 0 || sb_if.drained !== 1'b1) begin
            n_fail++;
            $display("FAIL sbsh_empty: got %0d pending, drained=%b, expected 0 1", exp_q.size(), sb_if.drained);
            exp_q.delete();
        end
    endtask

    task automatic test_reject();
        sb_if.mem_wready = 1'b1;
        send(ST_SH, 32'h0000_0021, 32'h0000_5555);
        n_tests++;
        if (sb_if.st_err !== 1'b1 || sb_if.count !== CW'(0)) begin
            n_fail++;
            $display("FAIL reject_sh: got st_err=%b count=%0d, expected 1 0", sb_if.st_err, sb_if.count);
        end
        send(ST_SW, 32'h0000_0006, 32'h7777_7777);
        n_tests++;
        if (sb_if.st_err !== 1'b1 || sb_if.count !== CW'(0)) begin
            n_fail++;
            $display("FAIL reject_sw: got st_err=%b count=%0d, expected 1 0", sb_if.st_err, sb_if.count);
        end
        send(ST_RSV, 32'h0000_0000, 32'h0000_0001);
        n_tests++;
        if (sb_if.st_err !== 1'b1 || sb_if.mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_rsv: got st_err=%b mem_wvalid=%b, expected 1 0", sb_if.st_err, sb_if.mem_wvalid);
        end
        step();
        n_tests++;
        if (sb_if.st_err !== 1'b0 || sb_if.drained !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_pulse: got st_err=%b drained=%b, expected 0 1", sb_if.st_err, sb_if.drained);
        end
    endtask

    task automatic test_back_to_back();
        sb_if.mem_wready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(ST_SW, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            push(30'h40 + 30'(i), 32'hC0DE_0000 + 32'(i), 4'b1111);
        end
        n_tests++;
        if (sb_if.count !== CW'(DEPTH) || sb_if.st_ready !== 1'b0 || sb_if.drained !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count=%0d st_ready=%b drained=%b, expected 4 0 0", sb_if.count, sb_if.st_ready, sb_if.drained);
        end
        // Fifth store held while full: ignored, no error, head stable.
        sb_if.st_valid = 1'b1; sb_if.st_op = ST_SW; sb_if.st_addr = 32'h200; sb_if.st_data = 32'hCAFE_0005;
        step();
        step();
        n_tests++;
        if (sb_if.count !== CW'(DEPTH) || sb_if.st_err !== 1'b0 ||
            {sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {30'h40, 32'hC0DE_0000, 4'b1111}) begin
            n_fail++;
            $display("FAIL full_hold: got count=%0d err=%b head=%h/%h/%b, expected 4 0 040/c0de0000/1111",
                     sb_if.count, sb_if.st_err, sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
        end
        sb_if.mem_wready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = exp_q.pop_front();
            n_tests++;
            $display("[TB] drain addr=%h data=%h be=%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
            if (sb_if.mem_wvalid !== 1'b1 || {sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {got.addr, got.data, got.be}) begin
                n_fail++;
                $display("FAIL full_drain: got v=%b %h/%h/%b, expected 1 %h/%h/%b", sb_if.mem_wvalid, sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be, got.addr, got.data, got.be);
            end
            if (k == 1) push(30'h80, 32'hCAFE_0005, 4'b1111);
            step();
            if (k == 1) sb_if.st_valid = 1'b0;
            n_tests++;
            if (sb_if.count !== CW'(DEPTH - 1) || sb_if.st_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_count_%0d: got count=%0d st_ready=%b, expected 3 1", k, sb_if.count, sb_if.st_ready);
            end
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (sb_if.mem_wvalid && sb_if.mem_wready) begin
                got = exp_q.pop_front();
                n_tests++;
                $display("[TB] drain addr=%h data=%h be=%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
                if ({sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {got.addr, got.data, got.be}) begin
                    n_fail++;
                    $display("FAIL b2b_drain: got %h/%h/%b, expected %h/%h/%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be, got.addr, got.data, got.be);
                end
            end
            step();
        end
        n_tests++;
        if (exp_q.size() != 0 || sb_if.drained !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_empty: got %0d pending, drained=%b, expected 0 1", exp_q.size(), sb_if.drained);
            exp_q.delete();
        end
    endtask

    task automatic test_forward();
        logic        hit_exp;
        logic [31:0] data_exp;
        logic [3:0]  be_exp;
        sb_if.mem_wready = 1'b0;
        send(ST_SW, 32'h40, 32'h1111_1111);
        send(ST_SW, 32'h40, 32'h2222_2222);
        send(ST_SB, 32'h45, 32'h0000_0033);
        push(30'h10, 32'h1111_1111, 4'b1111);
        push(30'h10, 32'h2222_2222, 4'b1111);
        push(30'h11, 32'h3333_3333, 4'b0010);
        for (int q = 0; q < 3; q++) begin
            sb_if.ld_addr = 30'h10 + 30'(q);
            #1;
`ifdef STORE_BUF_FWD_EN
            hit_exp  = (q != 2);
            data_exp = (q == 0) ? 32'h2222_2222 : (q == 1) ? 32'h3333_3333 : 32'h0;
            be_exp   = (q == 0) ? 4'b1111 : (q == 1) ? 4'b0010 : 4'b0000;
`else
            hit_exp  = 1'b0;
            data_exp = 32'h0;
            be_exp   = 4'b0000;
`endif
            n_tests++;
            $display("[TB] lookup ld_addr=%h hit=%b data=%h be=%b", sb_if.ld_addr, sb_if.ld_hit, sb_if.ld_data, sb_if.ld_be);
            if ({sb_if.ld_hit, sb_if.ld_data, sb_if.ld_be} !== {hit_exp, data_exp, be_exp}) begin
                n_fail++;
                $display("FAIL fwd_%0d: got hit=%b data=%h be=%b, expected %b %h %b", q, sb_if.ld_hit, sb_if.ld_data, sb_if.ld_be, hit_exp, data_exp, be_exp);
            end
        end
        sb_if.mem_wready = 1'b1;
        #1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (sb_if.mem_wvalid && sb_if.mem_wready) begin
                got = exp_q.pop_front();
                n_tests++;
                $display("[TB] drain addr=%h data=%h be=%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be);
                if ({sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be} !== {got.addr, got.data, got.be}) begin
                    n_fail++;
                    $display("FAIL fwd_drain: got %h/%h/%b, expected %h/%h/%b", sb_if.mem_addr, sb_if.mem_wdata, sb_if.mem_be, got.addr, got.data, got.be);
                end
            end
            step();
        end
        n_tests++;
        if (exp_q.size() != 0 || sb_if.ld_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_empty: got %0d pending, ld_hit=%b, expected 0 0", exp_q.size(), sb_if.ld_hit);
            exp_q.delete();
        end
    endtask

    task automatic test_flush_reset();
        sb_if.mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) send(ST_SW, 32'h300 + 32'(4 * i), 32'hF00D_0000 + 32'(i));
        sb_if.flush = 1'b1;
        #1;
        n_tests++;
        if (sb_if.st_ready !== 1'b0 || sb_if.count !== CW'(3)) begin
            n_fail++;
            $display("FAIL flush_block: got st_ready=%b count=%0d, expected 0 3", sb_if.st_ready, sb_if.count);
        end
        sb_if.mem_wready = 1'b1;
        sb_if.st_valid = 1'b1; sb_if.st_op = ST_SW; sb_if.st_addr = 32'h400; sb_if.st_data = 32'h1;
        step();
        sb_if.st_valid = 1'b0;
        n_tests++;
        if (sb_if.count !== CW'(2) || sb_if.drained !== 1'b0 || sb_if.mem_wvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drain: got count=%0d drained=%b mem_wvalid=%b, expected 2 0 1", sb_if.count, sb_if.drained, sb_if.mem_wvalid);
        end
        reset = 1'b1;
        step();
        n_tests++;
        if (sb_if.count !== CW'(0) || sb_if.drained !== 1'b1 || sb_if.mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got count=%0d drained=%b mem_wvalid=%b, expected 0 1 0", sb_if.count, sb_if.drained, sb_if.mem_wvalid);
        end
        reset = 1'b0;
        sb_if.flush = 1'b0;
        step();
        n_tests++;
        if (sb_if.st_ready !== 1'b1 || sb_if.mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: got st_ready=%b mem_wvalid=%b, expected 1 0", sb_if.st_ready, sb_if.mem_wvalid);
        end
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_sb_sh();
        test_reject();
        test_back_to_back();
        test_forward();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
